// File: rtl/pipelined_adder.sv
// Chunked ripple-carry adder/subtractor pipeline: one CHUNK-bit slice per stage,
// with a single global advance enable providing valid/ready backpressure.
module pipelined_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  // WIDTH must be a whole multiple of CHUNK.
  localparam int unsigned STAGES = WIDTH / CHUNK;
  localparam int unsigned LAST   = STAGES - 1;
  localparam int unsigned CW     = CHUNK + 1;

  // Per-stage registers: valid, carry, operands and the partially built sum.
  logic             r_v   [STAGES];
  logic             r_c   [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_s   [STAGES];
  logic             r_ovf;

  // Per-stage inputs and results.
  logic             w_v_in  [STAGES];
  logic             w_c_in  [STAGES];
  logic [WIDTH-1:0] w_a_in  [STAGES];
  logic [WIDTH-1:0] w_b_in  [STAGES];
  logic [WIDTH-1:0] w_s_in  [STAGES];
  logic [WIDTH-1:0] w_s_nxt [STAGES];
  logic [CW-1:0]    w_sum   [STAGES];
  logic             w_ovf;
  logic             w_adv;

  // Stage datapath; subtraction is folded in at the entry as ~B with carry-in 1.
  always_comb begin
    w_adv     = !r_v[LAST] || out_ready;
    w_v_in[0] = in_valid;
    w_a_in[0] = a;
    w_b_in[0] = sub ? ~b : b;
    w_c_in[0] = sub | cin;
    w_s_in[0] = '0;
    for (int k = 1; k < int'(STAGES); k++) begin
      w_v_in[k] = r_v[k-1];
      w_a_in[k] = r_a[k-1];
      w_b_in[k] = r_b[k-1];
      w_c_in[k] = r_c[k-1];
      w_s_in[k] = r_s[k-1];
    end
    for (int k = 0; k < int'(STAGES); k++) begin
      w_sum[k]   = CW'(w_a_in[k][k*CHUNK +: CHUNK]) + CW'(w_b_in[k][k*CHUNK +: CHUNK])
                 + CW'(w_c_in[k]);
      w_s_nxt[k] = w_s_in[k];
      w_s_nxt[k][k*CHUNK +: CHUNK] = w_sum[k][CHUNK-1:0];
    end
    w_ovf = (w_a_in[LAST][WIDTH-1] == w_b_in[LAST][WIDTH-1]) &&
            (w_s_nxt[LAST][WIDTH-1] != w_a_in[LAST][WIDTH-1]);
  end

  // Whole pipeline shifts together on w_adv; bubble slots leave stage data untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        r_v[k] <= 1'b0;
        r_c[k] <= 1'b0;
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
      end
      r_ovf <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        r_v[k] <= w_v_in[k];
        if (w_v_in[k]) begin
          r_c[k] <= w_sum[k][CHUNK];
          r_a[k] <= w_a_in[k];
          r_b[k] <= w_b_in[k];
          r_s[k] <= w_s_nxt[k];
        end
      end
      if (w_v_in[LAST]) r_ovf <= w_ovf;
    end
  end

  assign in_ready  = w_adv;
  assign out_valid = r_v[LAST];
  assign s         = r_s[LAST];
  assign cout      = r_c[LAST];
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: signed/unsigned arithmetic model with an in-order
// result queue, directed corner cases, random streams with backpressure and reset.
module tb_pipelined_adder;

  localparam int unsigned W      = 16;
  localparam int unsigned C      = 4;
  localparam int unsigned STAGES = W / C;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, s;

  logic         in_valid8, in_ready8, out_valid8, out_ready8, cout8, ovf8;
  logic [7:0]   a8, b8, s8;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
  );

  pipelined_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(1'b0), .sub(1'b0), .out_valid(out_valid8),
    .out_ready(out_ready8), .s(s8), .cout(cout8), .ovf(ovf8)
  );

  typedef struct {
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  int   n_in   = 0;
  int   n_out  = 0;
  res_t exp_q[$];
  logic hold = 1'b0;
  res_t held;
  logic tog_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain unsigned and signed integer arithmetic.
  function automatic res_t model(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                 input logic fc, input logic fs);
    int unsigned u;
    int          sr;
    res_t        r;
    if (fs) begin
      u  = int'(fa) + 32'h1_0000 - int'(fb);
      sr = int'($signed(fa)) - int'($signed(fb));
    end else begin
      u  = int'(fa) + int'(fb) + int'(fc);
      sr = int'($signed(fa)) + int'($signed(fb)) + int'(fc);
    end
    r.s    = u[W-1:0];
    r.cout = u[W];
    r.ovf  = (sr > 32767) || (sr < -32768);
    return r;
  endfunction

  // Per-cycle compare, sampled mid-cycle while inputs and outputs are settled.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      hold = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_s", 32'(s), 32'd0);
      chk("rst_cout", 32'(cout), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid8", 32'(out_valid8), 32'd0);
    end else begin
      chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (hold) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_s", 32'(s), 32'(held.s));
        chk("stall_cout", 32'(cout), 32'(held.cout));
        chk("stall_ovf", 32'(ovf), 32'(held.ovf));
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("stale_result", 32'(out_valid), 32'd0);
        end else begin
          chk("s", 32'(s), 32'(exp_q[0].s));
          chk("cout", 32'(cout), 32'(exp_q[0].cout));
          chk("ovf", 32'(ovf), 32'(exp_q[0].ovf));
          if (out_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
      end
      hold      = out_valid && !out_ready;
      held.s    = s;
      held.cout = cout;
      held.ovf  = ovf;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a, b, cin, sub));
        n_in++;
      end
    end
  end

  always @(posedge clk) begin
    if (tog_en) begin
      #1 out_ready = 1'($urandom_range(1, 0));
    end
  end

  // Single transaction with literal expectations and latency count; call just after an edge.
  task automatic send_dir(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, input logic ts, input logic [W-1:0] es,
                          input logic ec, input logic eo);
    int n;
    in_valid = 1'b1; a = ta; b = tb_; cin = tc; sub = ts;
    @(posedge clk); #1;
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = ~tc; sub = ~ts;
    n = 0;
    while (!out_valid && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'(STAGES - 1));
    chk({name, "_s"}, 32'(s), 32'(es));
    chk({name, "_cout"}, 32'(cout), 32'(ec));
    chk({name, "_ovf"}, 32'(ovf), 32'(eo));
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_count"}, 32'(n_out), 32'(n_in));
  endtask

  initial begin
    res_t m;
    int   base;
    logic acc;

    reset = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; out_ready8 = 1'b1;

    m = model(16'h00FF, 16'h0001, 1'b0, 1'b0);
    chk("model_carry_s", 32'(m.s), 32'h0100);
    m = model(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    chk("model_ovf_add", 32'(m.ovf), 32'd1);
    m = model(16'h0005, 16'h0007, 1'b1, 1'b1);
    chk("model_sub_s", 32'(m.s), 32'hFFFE);
    chk("model_sub_borrow", 32'(m.cout), 32'd0);

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    send_dir("add_00ff", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    send_dir("add_ffff", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    send_dir("add_7fff", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    send_dir("sub_5_7", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send_dir("sub_8000", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    in_valid8 = 1'b1; a8 = 8'h80; b8 = 8'h80;
    @(posedge clk); #1;
    in_valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    chk("w8_valid", 32'(out_valid8), 32'd1);
    chk("w8_s", 32'(s8), 32'h00);
    chk("w8_cout", 32'(cout8), 32'd1);
    chk("w8_ovf", 32'(ovf8), 32'd1);

    // Eight back-to-back operand sets under random backpressure.
    base = n_out;
    tog_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      a = W'($urandom); b = W'($urandom);
      cin = 1'($urandom_range(1, 0)); sub = 1'($urandom_range(1, 0));
      acc = 1'b0;
      for (int t = 0; t < 40 && !acc; t++) begin
        @(negedge clk);
        acc = in_ready;
        @(posedge clk); #1;
      end
      chk("burst_accepted", 32'(acc), 32'd1);
    end
    in_valid = 1'b0;
    tog_en = 1'b0;
    @(posedge clk); #2;
    drain("burst");
    chk("burst_results", 32'(n_out - base), 32'd8);

    // Long stream with bubbles, backpressure and operands changing every cycle.
    tog_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      in_valid = ($urandom_range(3, 0) != 0);
      a = W'($urandom); b = W'($urandom);
      cin = 1'($urandom_range(1, 0)); sub = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    tog_en = 1'b0;
    @(posedge clk); #2;
    drain("stream");

    // Fill the pipe under a stall, then reset with transactions in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("prefill_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_s", 32'(s), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    n_in = 0; n_out = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_quiet", 32'(out_valid), 32'd0);
    send_dir("post_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    drain("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
